rs_latch_sequencer: RTL and testbench

RS_LATCH_SEQUENCER -- requirements
Module: rs_latch_sequencer

---
 rtl/rs_latch_sequencer.sv | 125 ++++++++++++
 tb/tb_rs_latch_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_latch_sequencer.sv
// Sequencer for a bank of gated RS latches: arbitrates two requesters round-robin
// and applies one set/clear write as SETUP -> ENABLE (ENA_CYCLES) -> HOLD, with every output registered.
module rs_latch_sequencer #(
    parameter int NBITS      = 4,
    parameter int ENA_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [NBITS-1:0] SET0,
    input  logic [NBITS-1:0] SET1,
    input  logic [NBITS-1:0] CLR0,
    input  logic [NBITS-1:0] CLR1,
    output logic             ACK0,
    output logic             ACK1,
    output logic             ERR,
    output logic             BUSY,
    output logic             LAT_ENA,
    output logic [NBITS-1:0] LAT_S,
    output logic [NBITS-1:0] LAT_R
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ENABLE,
        HOLD
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ENA_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             prio_q, prio_d;
    logic             grant_q, grant_d;
    logic [NBITS-1:0] set_q, set_d;
    logic [NBITS-1:0] clr_q, clr_d;

    logic             ack0_d, ack1_d, err_d, busy_d, lat_ena_d;
    logic [NBITS-1:0] lat_s_d, lat_r_d;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        grant_d = grant_q;
        set_d   = set_q;
        clr_d   = clr_q;

        case (state_q)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    grant_d = (REQ0 && REQ1) ? prio_q : REQ1;
                    set_d   = grant_d ? SET1 : SET0;
                    clr_d   = grant_d ? CLR1 : CLR0;
                    prio_d  = ~grant_d;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = ENABLE;
            end
            ENABLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it once registered.
        lat_s_d   = (state_d != IDLE) ? (set_d & ~clr_d) : '0;
        lat_r_d   = (state_d != IDLE) ? (clr_d & ~set_d) : '0;
        lat_ena_d = (state_d == ENABLE);
        ack0_d    = (state_d == HOLD) && !grant_d;
        ack1_d    = (state_d == HOLD) && grant_d;
        err_d     = (state_d == HOLD) && ((set_d & clr_d) != '0);
        // BUSY stretches through the IDLE cycle that follows HOLD: ENA_CYCLES+3 cycles per write.
        busy_d    = (state_d != IDLE) || (state_q == HOLD);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            grant_q <= 1'b0;
            set_q   <= '0;
            clr_q   <= '0;
            ACK0    <= 1'b0;
            ACK1    <= 1'b0;
            ERR     <= 1'b0;
            BUSY    <= 1'b0;
            LAT_ENA <= 1'b0;
            LAT_S   <= '0;
            LAT_R   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            grant_q <= grant_d;
            set_q   <= set_d;
            clr_q   <= clr_d;
            ACK0    <= ack0_d;
            ACK1    <= ack1_d;
            ERR     <= err_d;
            BUSY    <= busy_d;
            LAT_ENA <= lat_ena_d;
            LAT_S   <= lat_s_d;
            LAT_R   <= lat_r_d;
        end
    end

endmodule

// File: tb/tb_rs_latch_sequencer.sv
// Bench for rs_latch_sequencer: three instances (ENA_CYCLES 2, 1, 15) on shared stimulus,
// a cycle-indexed transaction model, directed vectors and a randomized run.
module tb_rs_latch_sequencer;

    localparam int NB = 4;

    logic          clk, rst, req0, req1;
    logic [NB-1:0] set0, clr0, set1, clr1;
    logic [NB-1:0] lat_s [3];
    logic [NB-1:0] lat_r [3];
    logic          lat_ena [3];
    logic          ack0 [3];
    logic          ack1 [3];
    logic          err [3];
    logic          busy [3];

    int checks = 0;
    int errors = 0;

    function automatic int ena_of(int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 15;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rs_latch_sequencer #(
            .NBITS     (NB),
            .ENA_CYCLES((g == 0) ? 2 : (g == 1) ? 1 : 15)
        ) u_dut (
            .CLK    (clk),
            .RST    (rst),
            .REQ0   (req0),
            .REQ1   (req1),
            .SET0   (set0),
            .SET1   (set1),
            .CLR0   (clr0),
            .CLR1   (clr1),
            .ACK0   (ack0[g]),
            .ACK1   (ack1[g]),
            .ERR    (err[g]),
            .BUSY   (busy[g]),
            .LAT_ENA(lat_ena[g]),
            .LAT_S  (lat_s[g]),
            .LAT_R  (lat_r[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pos counts cycles into the current write (0 = idle,
    // 1 = setup, 2..e+1 = enable, e+2 = hold); post marks the cycle after hold.
    typedef struct {
        int            pos;
        bit            post;
        bit            prio;
        bit            grant;
        logic [NB-1:0] s;
        logic [NB-1:0] c;
    } model_t;

    typedef struct {
        logic [NB-1:0] s;
        logic [NB-1:0] r;
        bit            ena;
        bit            a0;
        bit            a1;
        bit            err;
        bit            busy;
    } exp_t;

    model_t mdl [3];

    function automatic model_t model_step(model_t m, int e, logic rs, logic r0, logic r1,
                                          logic [NB-1:0] s0, logic [NB-1:0] c0,
                                          logic [NB-1:0] s1, logic [NB-1:0] c1);
        model_t n = m;
        if (rs) begin
            n.pos  = 0;
            n.post = 1'b0;
            n.prio = 1'b0;
            return n;
        end
        n.post = (m.pos == e + 2);
        if (m.pos == 0) begin
            if (r0 || r1) begin
                n.grant = (r0 && r1) ? m.prio : r1;
                n.s     = n.grant ? s1 : s0;
                n.c     = n.grant ? c1 : c0;
                n.prio  = !n.grant;
                n.pos   = 1;
            end
        end else begin
            n.pos = (m.pos == e + 2) ? 0 : m.pos + 1;
        end
        return n;
    endfunction

    function automatic exp_t model_out(model_t m, int e);
        exp_t x;
        bit act = (m.pos != 0);
        x.s    = act ? (m.s & ~m.c) : '0;
        x.r    = act ? (m.c & ~m.s) : '0;
        x.ena  = (m.pos >= 2) && (m.pos <= e + 1);
        x.a0   = (m.pos == e + 2) && !m.grant;
        x.a1   = (m.pos == e + 2) && m.grant;
        x.err  = (m.pos == e + 2) && ((m.s & m.c) != '0);
        x.busy = act || m.post;
        return x;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            mdl[i] <= model_step(mdl[i], ena_of(i), rst, req0, req1, set0, clr0, set1, clr1);
    end

    logic [NB-1:0] prev_s [3];
    logic [NB-1:0] prev_r [3];
    logic          prev_ena [3];

    always @(negedge clk) begin
        exp_t ex;
        for (int i = 0; i < 3; i++) begin
            ex = model_out(mdl[i], ena_of(i));
            check("model_lat_s", i, 32'(lat_s[i]), 32'(ex.s));
            check("model_lat_r", i, 32'(lat_r[i]), 32'(ex.r));
            check("model_lat_ena", i, 32'(lat_ena[i]), 32'(ex.ena));
            check("model_ack0", i, 32'(ack0[i]), 32'(ex.a0));
            check("model_ack1", i, 32'(ack1[i]), 32'(ex.a1));
            check("model_err", i, 32'(err[i]), 32'(ex.err));
            check("model_busy", i, 32'(busy[i]), 32'(ex.busy));
            checks++;
            assert ((lat_s[i] & lat_r[i]) == '0)
            else begin
                errors++;
                $display("FAIL s_r_overlap dut%0d got S=%b R=%b required no common 1", i, lat_s[i], lat_r[i]);
            end
            if (prev_ena[i] === 1'b1 && lat_ena[i] === 1'b1) begin
                checks++;
                assert (lat_s[i] == prev_s[i] && lat_r[i] == prev_r[i])
                else begin
                    errors++;
                    $display("FAIL sr_stable_in_enable dut%0d got S=%b R=%b required S=%b R=%b",
                             i, lat_s[i], lat_r[i], prev_s[i], prev_r[i]);
                end
            end
            prev_s[i]   <= lat_s[i];
            prev_r[i]   <= lat_r[i];
            prev_ena[i] <= lat_ena[i];
        end
    end

    task automatic check_outs(input string tag, input logic [NB-1:0] s, input logic [NB-1:0] r,
                              input logic ena, input logic a0, input logic a1,
                              input logic er, input logic bz);
        check({tag, ".lat_s"}, 0, 32'(lat_s[0]), 32'(s));
        check({tag, ".lat_r"}, 0, 32'(lat_r[0]), 32'(r));
        check({tag, ".lat_ena"}, 0, 32'(lat_ena[0]), 32'(ena));
        check({tag, ".ack0"}, 0, 32'(ack0[0]), 32'(a0));
        check({tag, ".ack1"}, 0, 32'(ack1[0]), 32'(a1));
        check({tag, ".err"}, 0, 32'(err[0]), 32'(er));
        check({tag, ".busy"}, 0, 32'(busy[0]), 32'(bz));
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input string tag, output int cyc);
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ack0[0] || ack1[0]) begin
                cyc = k;
                break;
            end
        end
        if (cyc == 0) begin
            checks++;
            errors++;
            $display("FAIL %s ack_timeout got no ACK expected one within 40 cycles", tag);
        end
    endtask

    typedef struct {
        logic          r0, r1;
        logic [NB-1:0] s0, c0, s1, c1;
        logic [NB-1:0] es, er;
        logic          ea0, ea1, eerr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int cyc;
        int n_ena1, n_busy1, n_ena15, n_busy15, n_ena2, n_busy2;

        vecs = '{
            '{1'b1, 1'b0, 4'b0101, 4'b1010, 4'b0000, 4'b0000, 4'b0101, 4'b1010, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0011, 4'b0110, 4'b0001, 4'b0100, 1'b0, 1'b1, 1'b1},
            '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1000, 4'b0111, 4'b1000, 4'b0111, 1'b0, 1'b1, 1'b0},
            '{1'b1, 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1},
            '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b1001, 1'b0, 1'b1, 1'b0}
        };

        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        set0 = '0;
        clr0 = '0;
        set1 = '0;
        clr1 = '0;
        @(negedge clk);
        check_outs("reset_state", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Single write from requester 0 traced cycle by cycle.
        req0 = 1'b1;
        set0 = 4'b0101;
        clr0 = 4'b1010;
        @(negedge clk);
        check_outs("basic_t1", 4'b0101, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_outs("basic_t2", 4'b0101, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_outs("basic_t3", 4'b0101, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_outs("basic_t4", 4'b0101, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        req0 = 1'b0;
        @(negedge clk);
        check_outs("basic_t5", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_outs("basic_t6", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Table of single transactions, each from a fresh reset.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            req0 = vecs[v].r0;
            req1 = vecs[v].r1;
            set0 = vecs[v].s0;
            clr0 = vecs[v].c0;
            set1 = vecs[v].s1;
            clr1 = vecs[v].c1;
            wait_ack($sformatf("vec%0d", v), cyc);
            check($sformatf("vec%0d.latency", v), 0, cyc, 4);
            check_outs($sformatf("vec%0d", v), vecs[v].es, vecs[v].er, 1'b0,
                       vecs[v].ea0, vecs[v].ea1, vecs[v].eerr, 1'b1);
            req0 = 1'b0;
            req1 = 1'b0;
            @(negedge clk);
        end

        // Round-robin: both requesting from reset, then requester 0 again.
        do_reset();
        set0 = 4'b0001;
        clr0 = 4'b0000;
        set1 = 4'b0010;
        clr1 = 4'b0000;
        req0 = 1'b1;
        req1 = 1'b1;
        wait_ack("rr_first", cyc);
        check("rr_first.latency", 0, cyc, 4);
        check_outs("rr_first", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        req0 = 1'b0;
        @(negedge clk);
        req0 = 1'b1;
        wait_ack("rr_second", cyc);
        check("rr_second.latency", 0, cyc, 4);
        check_outs("rr_second", 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        req1 = 1'b0;
        wait_ack("rr_third", cyc);
        check("rr_third.latency", 0, cyc, 5);
        check_outs("rr_third", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        req0 = 1'b0;
        @(negedge clk);

        // Reset during ENABLE aborts the write and restores priority to requester 0.
        do_reset();
        req0 = 1'b1;
        set0 = 4'b1100;
        clr0 = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        check("abort.in_enable", 0, 32'(lat_ena[0]), 32'd1);
        rst  = 1'b1;
        req0 = 1'b0;
        @(negedge clk);
        check_outs("abort_after_rst", '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort.no_ack", 0, 32'(ack0[0]), 32'd0);
        end
        set0 = 4'b0001;
        clr0 = 4'b0000;
        set1 = 4'b1111;
        clr1 = 4'b0000;
        req0 = 1'b1;
        req1 = 1'b1;
        wait_ack("post_abort", cyc);
        check_outs("post_abort", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        req0 = 1'b0;
        wait_ack("post_abort_r1", cyc);
        check("post_abort_r1.ack1", 0, 32'(ack1[0]), 32'd1);
        req1 = 1'b0;
        @(negedge clk);

        // Enable-window and busy-window lengths for ENA_CYCLES 2, 1 and 15.
        do_reset();
        n_ena1 = 0; n_busy1 = 0; n_ena15 = 0; n_busy15 = 0; n_ena2 = 0; n_busy2 = 0;
        set0 = 4'b0110;
        clr0 = 4'b0000;
        req0 = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            req0 = 1'b0;
            n_ena2   += int'(lat_ena[0]);
            n_busy2  += int'(busy[0]);
            n_ena1   += int'(lat_ena[1]);
            n_busy1  += int'(busy[1]);
            n_ena15  += int'(lat_ena[2]);
            n_busy15 += int'(busy[2]);
        end
        check("width.ena_e2", 0, n_ena2, 2);
        check("width.busy_e2", 0, n_busy2, 5);
        check("width.ena_e1", 1, n_ena1, 1);
        check("width.busy_e1", 1, n_busy1, 4);
        check("width.ena_e15", 2, n_ena15, 15);
        check("width.busy_e15", 2, n_busy15, 18);

        // Randomized traffic; the per-cycle model comparison does the checking.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 199) == 0);
            req0 = ($urandom_range(0, 2) == 0);
            req1 = ($urandom_range(0, 2) == 0);
            set0 = NB'($urandom);
            clr0 = NB'($urandom);
            set1 = NB'($urandom);
            clr1 = NB'($urandom);
        end
        do_reset();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
